press_classifier: RTL

PRESS_CLASSIFIER -- requirements
Module: press_classifier

---
 rtl/press_classifier.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/press_classifier.sv
// Button press classifier: short, long and double press events from a debounced level.
// Optional event counter enabled by defining PRESS_CLASSIFIER_EVT_CNT_EN.
`timescale 1ns/1ps
module press_classifier #(
    parameter int TICK_DIV   = 1000000,
    parameter int LONG_TICKS = 50,
    parameter int GAP_TICKS  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       db,
    output logic       short_p,
    output logic       long_p,
    output logic       dbl_p,
    output logic       busy,
    output logic [7:0] evt_cnt
);
    localparam int MAXT = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
    localparam int CW   = $clog2(MAXT) + 1;
    localparam int PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_WAIT_GAP  = 3'd2,
        S_PRESS2    = 3'd3,
        S_LONG_HOLD = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            db_q;
    logic            blk_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            short_q, short_d;
    logic            long_q, long_d;
    logic            dbl_q, dbl_d;
    logic            busy_q;
    logic            tick_s, rise_s, fall_s;

    // blk_q holds off rise detection after reset until db has been seen low,
    // so a switch held through reset does not start a sequence.
    assign tick_s = (presc_q == PRESC_LAST);
    assign rise_s = db & ~db_q & ~blk_q;
    assign fall_s = ~db & db_q;

    // Next-state and pulse decision
    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise_s) state_d = S_PRESS1;
                else        state_d = state_q;
            end
            S_PRESS1: begin
                if (fall_s) begin
                    state_d = S_WAIT_GAP;
                end else if (tick_s && (cnt_q == LONG_LAST)) begin
                    state_d = S_LONG_HOLD;
                    long_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT_GAP: begin
                if (rise_s) begin
                    state_d = S_PRESS2;
                end else if (tick_s && (cnt_q == GAP_LAST)) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_PRESS2: begin
                if (fall_s) begin
                    state_d = S_IDLE;
                    dbl_d   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_LONG_HOLD: begin
                if (fall_s) state_d = S_IDLE;
                else        state_d = state_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Prescaler wrap and saturating tick counter, cleared on any state change
    always_comb begin
        if (tick_s) presc_d = {PW{1'b0}};
        else        presc_d = presc_q + PW'(1);
        if (state_d != state_q)                  cnt_d = {CW{1'b0}};
        else if (tick_s && (cnt_q != CNT_MAX))   cnt_d = cnt_q + CW'(1);
        else                                     cnt_d = cnt_q;
    end

    // State, timing and registered output flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            db_q    <= 1'b0;
            blk_q   <= 1'b1;
            presc_q <= {PW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            db_q    <= db;
            blk_q   <= blk_q & db;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign short_p = short_q;
    assign long_p  = long_q;
    assign dbl_p   = dbl_q;
    assign busy    = busy_q;

`ifdef PRESS_CLASSIFIER_EVT_CNT_EN
    logic [7:0] evt_q;

    // Event counter, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_q <= 8'd0;
        end else if (short_q | long_q | dbl_q) begin
            evt_q <= evt_q + 8'd1;
        end else begin
            evt_q <= evt_q;
        end
    end

    assign evt_cnt = evt_q;
`else
    assign evt_cnt = 8'd0;
`endif

endmodule
